// File: rtl/ula_pkg.sv
// Shared definitions for the ula sequencer: opcodes, FSM states, flag bit
// positions and the flag computation used when a result is captured.
package ula_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd2;
   localparam logic [2:0] OP_SHR = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_NOT = 3'd7;

   localparam int CMD_W = 12;

   localparam int FLG_C = 3;
   localparam int FLG_V = 2;
   localparam int FLG_N = 1;
   localparam int FLG_Z = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      OUT   = 2'd2
   } state_t;

   // Flags {C,V,N,Z}. C and V are derived from the operands rather than from
   // S, so the carry/borrow out of bit 3 is visible even though S is 4 bits.
   function automatic logic [3:0] calc_flags(input logic [2:0] op,
                                             input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [3:0] s);
      logic [4:0] sum;
      logic [4:0] diff;
      logic [3:0] f;
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      f    = 4'b0000;
      case (op)
         OP_ADD: begin
            f[FLG_C] = sum[4];
            f[FLG_V] = (a[3] == b[3]) && (sum[3] != a[3]);
         end
         OP_SUB: begin
            // diff[4] is the borrow, i.e. a < b unsigned
            f[FLG_C] = diff[4];
            f[FLG_V] = (a[3] != b[3]) && (diff[3] != a[3]);
         end
         default: begin
            f[FLG_C] = 1'b0;
            f[FLG_V] = 1'b0;
         end
      endcase
      f[FLG_N] = s[3];
      f[FLG_Z] = (s == 4'd0);
      return f;
   endfunction

endpackage

// File: rtl/ula_cmd_fifo.sv
// Command FIFO for ula_seq: 12-bit entries, DEPTH entries (power of two).
// Ports: push/din write the tail when not full; pop advances the head when
// not empty; dout shows the head entry; full/empty report occupancy.
module ula_cmd_fifo
   import ula_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [CMD_W-1:0] din,
   output logic [CMD_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == '0);
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign dout      = mem_r[rd_ptr_r];

   // Storage array; contents need no reset because count gates all reads.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ula_seq.sv
// Sequencing front end for the 4-bit ula datapath.
// Ports: cmd_* valid/ready command input (buffered in a FIFO); alu_a/alu_b and
// alu_x/y/z are the registered operands/selects to ula; alu_s is ula's result;
// res_* valid/ready result output with {C,V,N,Z} flags; acc holds the last
// result for chained operations; busy is high while work is pending.
module ula_seq
   import ula_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_x,
   output logic [2:0] alu_y,
   output logic [2:0] alu_z,
   input  logic [3:0] alu_s,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic [3:0] res_flags,
   output logic [3:0] acc,
   output logic       busy
);

   state_t           state_r;
   state_t           state_nx_s;
   logic             pop_s;
   logic             cap_s;
   logic             full_s;
   logic             empty_s;
   logic [CMD_W-1:0] head_s;
   logic [2:0]       op_r_s;

   assign cmd_ready = !full_s;
   assign busy      = (state_r != IDLE) || !empty_s;
   assign op_r_s    = {alu_z[0], alu_y[0], alu_x[0]};

   ula_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .pop   (pop_s),
      .din   ({cmd_op, cmd_a, cmd_b, cmd_use_acc}),
      .dout  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Next-state logic: pops happen from IDLE, or from OUT on a handshake.
   always_comb begin
      state_nx_s = state_r;
      pop_s      = 1'b0;
      cap_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s      = 1'b1;
               state_nx_s = DRIVE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         DRIVE: begin
            cap_s      = 1'b1;
            state_nx_s = OUT;
         end
         OUT: begin
            if (res_ready) begin
               if (!empty_s) begin
                  pop_s      = 1'b1;
                  state_nx_s = DRIVE;
               end else begin
                  state_nx_s = IDLE;
               end
            end else begin
               state_nx_s = OUT;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Operand/select registers toward ula; acc already holds any earlier
   // capture because a pop never shares an edge with a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a <= 4'd0;
         alu_b <= 4'd0;
         alu_x <= 3'd0;
         alu_y <= 3'd0;
         alu_z <= 3'd0;
      end else if (pop_s) begin
         alu_a <= head_s[0] ? acc : head_s[8:5];
         alu_b <= head_s[4:1];
         alu_x <= {2'b00, head_s[9]};
         alu_y <= {2'b00, head_s[10]};
         alu_z <= {2'b00, head_s[11]};
      end
   end

   // Result capture; res_valid drops on the handshake edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= 4'd0;
         res_flags <= 4'd0;
         acc       <= 4'd0;
      end else if (cap_s) begin
         res_valid <= 1'b1;
         res_data  <= alu_s;
         res_flags <= calc_flags(op_r_s, alu_a, alu_b, alu_s);
         acc       <= alu_s;
      end else if ((state_r == OUT) && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_use_acc;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_x;
   logic [2:0] alu_y;
   logic [2:0] alu_z;
   logic [3:0] alu_s;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic [3:0] res_flags;
   logic [3:0] acc;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [3:0] m_acc;

   always #5 clk = ~clk;

   ula_seq #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
      .alu_s(alu_s), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flags(res_flags), .acc(acc), .busy(busy)
   );

   // Closed-loop stand-in for the combinational ula datapath.
   always_comb begin
      alu_s = 4'd0;
      case ({alu_z[0], alu_y[0], alu_x[0]})
         3'd0:    alu_s = alu_a + alu_b;
         3'd1:    alu_s = alu_a - alu_b;
         3'd2:    alu_s = alu_a << alu_b;
         3'd3:    alu_s = alu_a >> alu_b;
         3'd4:    alu_s = alu_a & alu_b;
         3'd5:    alu_s = alu_a | alu_b;
         3'd6:    alu_s = alu_a ^ alu_b;
         3'd7:    alu_s = ~alu_a;
         default: alu_s = 4'd0;
      endcase
   end

   // Reference: {C,V,N,Z,data} from integer arithmetic on the operand values.
   function automatic logic [7:0] ref_result(int op, int a, int b);
      int r, sa, sb;
      bit c, v;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      c = 1'b0;
      v = 1'b0;
      r = 0;
      case (op)
         0: begin r = a + b; c = (r > 15); v = ((sa + sb) > 7) || ((sa + sb) < -8); r = r % 16; end
         1: begin r = (a - b + 16) % 16; c = (a < b); v = ((sa - sb) > 7) || ((sa - sb) < -8); end
         2: r = (b >= 4) ? 0 : (a * (1 << b)) % 16;
         3: r = (b >= 4) ? 0 : a / (1 << b);
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         default: r = 15 - a;
      endcase
      return {c, v, (r >= 8), (r == 0), r[3:0]};
   endfunction

   task automatic model_push(input logic [2:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic ua);
      logic [3:0] ea;
      logic [7:0] r;
      ea = ua ? m_acc : a;
      r = ref_result(int'(op), int'(ea), int'(b));
      m_acc = r[3:0];
      exp_q.push_back(r);
   endtask

   task automatic model_reset();
      m_acc = 4'd0;
      exp_q.delete();
   endtask

   // Present one command and hold it until accepted (bounded).
   task automatic push_one(input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic ua);
      bit ok;
      ok = 1'b0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            model_push(op, a, b, ua);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL push_timeout: cmd_ready=%0b required 1 within 50 cycles", cmd_ready);
      end
   endtask

   task automatic wait_res();
      for (int i = 0; i < 40; i++) begin
         if (res_valid) break;
         @(posedge clk); #1;
      end
      checks++;
      if (!res_valid) begin
         errors++;
         $display("FAIL res_timeout: res_valid=%0b required 1 within 40 cycles", res_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0;
      cmd_use_acc = 1'b0; res_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({alu_a, alu_b, alu_x, alu_y, alu_z, res_valid, res_data, res_flags, acc} !== 30'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %0h required 0",
                  {alu_a, alu_b, alu_x, alu_y, alu_z, res_valid, res_data, res_flags, acc});
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_busy: got ready=%0b busy=%0b required 1/0", cmd_ready, busy);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      res_ready = 1'b0;
      cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd9; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
      model_push(3'd0, 4'd7, 4'd9, 1'b0);
      @(posedge clk); #1;          // push edge t
      cmd_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL add_t0: got valid=%0b busy=%0b required 0/1", res_valid, busy);
      end
      @(posedge clk); #1;          // pop edge t+1
      checks++;
      if (res_valid !== 1'b0 || alu_a !== 4'd7 || alu_b !== 4'd9 || {alu_x, alu_y, alu_z} !== 9'd0) begin
         errors++;
         $display("FAIL add_t1: got valid=%0b a=%0d b=%0d sel=%0h required 0/7/9/0",
                  res_valid, alu_a, alu_b, {alu_x, alu_y, alu_z});
      end
      @(posedge clk); #1;          // capture edge t+2
      checks++;
      if (res_valid !== 1'b1 || res_data !== 4'd0 || res_flags !== 4'b1001 || acc !== 4'd0) begin
         errors++;
         $display("FAIL add_result: got valid=%0b data=%0h flags=%b acc=%0h required 1/0/1001/0",
                  res_valid, res_data, res_flags, acc);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_drain: got valid=%0b busy=%0b required 0/0", res_valid, busy);
      end
      exp_q.delete();
   endtask

   task automatic test_sub_acc();
      res_ready = 1'b0;
      push_one(3'd1, 4'd3, 4'd5, 1'b0);
      push_one(3'd0, 4'd9, 4'd2, 1'b1);
      res_ready = 1'b1;
      wait_res();
      checks++;
      if (res_data !== 4'b1110 || res_flags !== 4'b1010 || acc !== 4'b1110) begin
         errors++;
         $display("FAIL sub_result: got data=%b flags=%b acc=%b required 1110/1010/1110",
                  res_data, res_flags, acc);
      end
      @(posedge clk); #1;
      wait_res();
      checks++;
      if (res_data !== 4'd0 || res_flags !== 4'b1001) begin
         errors++;
         $display("FAIL add_acc_result: got data=%0h flags=%b required 0/1001", res_data, res_flags);
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_shift_not();
      logic [7:0] req [3];
      req[0] = 8'b0001_0000; req[1] = 8'b0000_0001; req[2] = 8'b0010_1010;
      res_ready = 1'b0;
      push_one(3'd2, 4'b0011, 4'd5, 1'b0);
      push_one(3'd3, 4'b1000, 4'd3, 1'b0);
      push_one(3'd7, 4'b0101, 4'd6, 1'b0);
      res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_res();
         checks++;
         if ({res_flags, res_data} !== req[k]) begin
            errors++;
            $display("FAIL shift_not_%0d: got flags/data=%b required %b", k, {res_flags, res_data}, req[k]);
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [12:0] cmds [DEPTH+2];
      logic [7:0]  held, exp;
      int n_acc, got, last_cyc;
      bit stable;
      for (int i = 0; i < DEPTH + 2; i++) cmds[i] = 13'($urandom);
      res_ready = 1'b0;
      n_acc = 0;
      for (int cyc = 0; cyc < 30 && n_acc < DEPTH + 2; cyc++) begin
         {cmd_op, cmd_a, cmd_b, cmd_use_acc} = cmds[n_acc][11:0];
         cmd_valid = 1'b1;
         if (!cmd_ready) break;
         model_push(cmd_op, cmd_a, cmd_b, cmd_use_acc);
         n_acc++;
         @(posedge clk); #1;
      end
      checks++;
      if (n_acc !== DEPTH + 1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_fill: got accepted=%0d ready=%0b required %0d/0", n_acc, cmd_ready, DEPTH + 1);
      end
      held = {res_flags, res_data};
      stable = res_valid;
      repeat (4) begin
         @(posedge clk); #1;
         if (!res_valid || {res_flags, res_data} !== held || cmd_ready) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL b2b_hold: got valid=%0b data=%0h ready=%0b required held stable", res_valid,
                  {res_flags, res_data}, cmd_ready);
      end
      res_ready = 1'b1;
      got = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 60 && got < DEPTH + 2; cyc++) begin
         if (cmd_valid && cmd_ready) begin
            model_push(cmd_op, cmd_a, cmd_b, cmd_use_acc);
            n_acc++;
         end
         if (res_valid) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if ({res_flags, res_data} !== exp) begin
               errors++;
               $display("FAIL b2b_data_%0d: got %b required %b", got, {res_flags, res_data}, exp);
            end
            if (got > 0) begin
               checks++;
               if (cyc - last_cyc != 2) begin
                  errors++;
                  $display("FAIL b2b_spacing_%0d: got %0d cycles required 2", got, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            got++;
         end
         @(posedge clk); #1;
         if (n_acc == DEPTH + 2) cmd_valid = 1'b0;
      end
      checks++;
      if (got != DEPTH + 2 || n_acc != DEPTH + 2) begin
         errors++;
         $display("FAIL b2b_count: got results=%0d accepted=%0d required %0d", got, n_acc, DEPTH + 2);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit quiet;
      res_ready = 1'b0;
      push_one(3'd0, 4'd1, 4'd2, 1'b0);
      push_one(3'd5, 4'd6, 4'd9, 1'b0);
      push_one(3'd6, 4'd3, 4'd4, 1'b0);
      push_one(3'd4, 4'd15, 4'd7, 1'b0);
      wait_res();
      res_ready = 1'b1;
      @(posedge clk); #1;          // handshake + pop: now in DRIVE with 2 queued
      res_ready = 1'b0;
      checks++;
      if (busy !== 1'b1 || alu_a !== 4'd6) begin
         errors++;
         $display("FAIL mid_pre: got busy=%0b alu_a=%0d required 1/6", busy, alu_a);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({alu_a, alu_b, alu_x, alu_y, alu_z, res_valid, res_data, res_flags, acc} !== 30'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %0h required 0",
                  {alu_a, alu_b, alu_x, alu_y, alu_z, res_valid, res_data, res_flags, acc});
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      res_ready = 1'b1;
      quiet = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (res_valid) quiet = 1'b0;
      end
      checks++;
      if (!quiet || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_after: got quiet=%0b busy=%0b ready=%0b required 1/0/1", quiet, busy, cmd_ready);
      end
      res_ready = 1'b0;
   endtask

   task automatic test_random();
      int sent, got;
      bit hold_prev, drop;
      logic [7:0] held, exp;
      sent = 0; got = 0; hold_prev = 1'b0; drop = 1'b0; held = 8'd0;
      cmd_valid = 1'b0;
      for (int cyc = 0; cyc < 2000 && got < 20; cyc++) begin
         if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
         if (hold_prev) begin
            checks++;
            if (!res_valid || {res_flags, res_data} !== held) begin
               errors++;
               $display("FAIL rand_stable: got valid=%0b data=%b required 1/%b", res_valid,
                        {res_flags, res_data}, held);
            end
         end
         res_ready = ($urandom_range(2, 0) != 0);
         if (!cmd_valid && sent < 20 && $urandom_range(2, 0) != 0) begin
            cmd_op = 3'($urandom_range(7, 0));
            cmd_a = 4'($urandom_range(15, 0));
            cmd_b = 4'($urandom_range(15, 0));
            cmd_use_acc = 1'($urandom_range(1, 0));
            cmd_valid = 1'b1;
         end
         if (res_valid && res_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if ({res_flags, res_data} !== exp) begin
               errors++;
               $display("FAIL rand_result_%0d: got %b required %b", got, {res_flags, res_data}, exp);
            end
            got++;
         end
         if (cmd_valid && cmd_ready) begin
            model_push(cmd_op, cmd_a, cmd_b, cmd_use_acc);
            sent++;
            drop = 1'b1;
         end
         hold_prev = res_valid && !res_ready;
         held = {res_flags, res_data};
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      checks++;
      if (got != 20 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_count: got %0d results (%0d pending) required 20/0", got, exp_q.size());
      end
      res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_acc();
      test_shift_not();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
